// File: rtl/switches_debouncer.sv
// switches_debouncer: two-flop synchroniser plus per-bit persistence debouncer with change pulses.
// Define SWITCHES_DEBOUNCER_CHANGE_LATCH_EN to enable the sticky change_latched flags.
module switches_debouncer #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] change_mask,
  output logic             sw_changed,
  input  logic [WIDTH-1:0] change_clear,
  output logic [WIDTH-1:0] change_latched
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [WIDTH-1:0] s1, s2, differ, accept;
  logic [CNT_W-1:0] cnt [WIDTH];
  always_comb begin
    differ = s2 ^ sw_stable;
    accept = '0;
    for (int i = 0; i < WIDTH; i++) accept[i] = differ[i] && cnt[i] == LAST;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1          <= '0;
      s2          <= '0;
      sw_stable   <= '0;
      change_mask <= '0;
      sw_changed  <= 1'b0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      s1          <= sw_raw;
      s2          <= s1;
      sw_stable   <= sw_stable ^ accept;
      change_mask <= accept;
      sw_changed  <= |accept;
      // any return to the stable level, or an acceptance, restarts the count
      for (int i = 0; i < WIDTH; i++) cnt[i] <= (differ[i] && !accept[i]) ? cnt[i] + CNT_W'(1) : '0;
    end
  end
`ifdef SWITCHES_DEBOUNCER_CHANGE_LATCH_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) change_latched <= '0;
    else change_latched <= (change_latched & ~change_clear) | change_mask;
  end
`else
  logic unused_clear;
  assign unused_clear   = ^change_clear;
  assign change_latched = '0;
`endif
endmodule

// File: doc/switches_debouncer.md
Name: switches_debouncer

Overview:
- Sits directly upstream of the switches PIO slave and drives its 8-bit `in_port`.
- Synchronises raw slide-switch inputs to `clk`, then debounces each bit independently with a per-bit persistence counter.
- Presents a glitch-free `sw_stable` vector, plus a one-cycle change indication per bit for firmware or IRQ logic.

Parameters:
- WIDTH, 8: number of switch bits.
- DEBOUNCE_CYCLES, 500000: consecutive cycles a new level must persist before it is accepted (10 ms at 50 MHz). Minimum 2.
- CNT_W, 19: counter width. Must hold DEBOUNCE_CYCLES-1.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- sw_raw  input  WIDTH  asynchronous switch pins.
- sw_stable  output  WIDTH  debounced switch levels; connects to PIO in_port.
- change_mask  output  WIDTH  one-cycle pulse per bit whose sw_stable value changed.
- sw_changed  output  1  OR of change_mask, registered together with it.
- change_clear  input  WIDTH  clear strobes for change_latched (optional feature).
- change_latched  output  WIDTH  sticky change flags (optional feature).

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While reset_n=0, the following are all 0:
  - sync stage 1 and sync stage 2
  - sw_stable, all counters
  - change_mask, sw_changed, change_latched

  Switches held high through reset appear on sw_stable after a normal debounce period.
- Reset mid-debounce discards partial counts. Deassertion is used as-is; the reset synchroniser is upstream.
- Synchroniser: two flip-flops per bit, sw_raw -> s1 -> s2. No logic between them.
- Per-bit counter, evaluated each cycle:
  - s2[i] == sw_stable[i]: cnt[i] <= 0, change_mask[i] <= 0.
  - s2[i] != sw_stable[i] and cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] <= cnt[i]+1, change_mask[i] <= 0.
  - s2[i] != sw_stable[i] and cnt[i] == DEBOUNCE_CYCLES-1: sw_stable[i] <= s2[i], cnt[i] <= 0, change_mask[i] <= 1.
- Any single-cycle return of s2 to the stable level restarts the count from 0. A pulse shorter than DEBOUNCE_CYCLES cycles never reaches sw_stable.
- Latency: if sw_raw changes and is first sampled at edge 0 and then held, sw_stable changes at edge DEBOUNCE_CYCLES+1.
  - change_mask/sw_changed assert in the cycle after that same edge, aligned with the new sw_stable value.
  - They stay high for exactly one cycle.
- Counter never exceeds DEBOUNCE_CYCLES-1. No wrap-around is possible.
- Bits are fully independent. Several bits may qualify on the same edge, giving multiple change_mask bits high together.
- A bit may toggle again immediately after acceptance. The next acceptance needs a further DEBOUNCE_CYCLES cycles of mismatch.

Optional Feature:
- Macro: SWITCHES_DEBOUNCER_CHANGE_LATCH_EN.
- Defined:
  - change_latched[i] sets when change_mask[i]=1 and clears when change_clear[i]=1.
  - Simultaneous set and clear: set wins.
  - Register update is one cycle after the strobe.
- Undefined: change_latched is tied to 0 and change_clear is ignored. The port list is unchanged.

Test Plan (DEBOUNCE_CYCLES=4 unless noted):
- Reset with sw_raw=8'hFF -> sw_stable=8'h00 during reset. After release, sw_stable=8'hFF at edge 5 after first sample, change_mask=8'hFF for one cycle, sw_changed=1 for one cycle.
- sw_raw[0] high for 3 cycles then low (glitch) -> sw_stable stays 8'h00, change_mask never asserts, cnt[0] returns to 0.
- sw_raw=8'h01 at edge 0, sw_raw=8'h03 at edge 2 -> sw_stable=8'h01 at edge 5, 8'h03 at edge 7, with separate one-cycle pulses change_mask=8'h01 then 8'h02.
- Assert reset_n=0 when cnt[3]=2 -> all outputs 0 immediately. After release with sw_raw[3] held, full DEBOUNCE_CYCLES+1 edges are needed before sw_stable[3]=1.
- With SWITCHES_DEBOUNCER_CHANGE_LATCH_EN defined:
  - bit 2 accepted -> change_latched=8'h04 persists.
  - change_clear=8'h04 for one cycle -> 8'h00.
  - Clear coincident with a new change on bit 2 -> stays 8'h04.
- Default DEBOUNCE_CYCLES=500000 and WIDTH=8: single bit toggle -> sw_stable updates exactly 500001 edges after first sample.
